// File: rtl/interval_timer.sv
// Prescaled interval timer: counts ticks up to a target loaded on start,
// in one-shot (sticky enable) or auto-reload (periodic done_pulse) mode.
module interval_timer #(
    parameter int PRESCALE = 195,
    parameter int PRE_W    = 8,
    parameter int COUNT_W  = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic               auto_reload,
    input  logic [COUNT_W-1:0] target,
    output logic [COUNT_W-1:0] count,
    output logic               enable,
    output logic               done_pulse,
    output logic               running
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    state_t               state, stateNext;
    logic [PRE_W-1:0]     prescaler, prescalerNext;
    logic [COUNT_W-1:0]   countNext;
    logic [COUNT_W-1:0]   targetQ, targetNext;
    logic                 modeQ, modeNext;
    logic                 pulseNext;
    logic                 tick;
    logic                 terminal;

    // A zero target counts as terminal on every tick so auto-reload with target 0 pulses per tick.
    assign tick     = (state == RUN) && !pause && (prescaler == PRE_LAST);
    assign terminal = (targetQ == '0) || (count == targetQ - COUNT_W'(1));

    always_comb begin
        stateNext     = state;
        prescalerNext = prescaler;
        countNext     = count;
        targetNext    = targetQ;
        modeNext      = modeQ;
        pulseNext     = 1'b0;

        if (start) begin
            targetNext    = target;
            modeNext      = auto_reload;
            prescalerNext = '0;
            countNext     = '0;
            if (target == '0) begin
                pulseNext = 1'b1;
                stateNext = auto_reload ? RUN : DONE;
            end else begin
                stateNext = RUN;
            end
        end else if (state == RUN && !pause) begin
            if (tick) begin
                prescalerNext = '0;
                if (terminal) begin
                    pulseNext = 1'b1;
                    if (modeQ) begin
                        countNext = '0;
                    end else begin
                        countNext = targetQ;
                        stateNext = DONE;
                    end
                end else begin
                    countNext = count + COUNT_W'(1);
                end
            end else begin
                prescalerNext = prescaler + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            prescaler  <= '0;
            count      <= '0;
            targetQ    <= '0;
            modeQ      <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            state      <= stateNext;
            prescaler  <= prescalerNext;
            count      <= countNext;
            targetQ    <= targetNext;
            modeQ      <= modeNext;
            done_pulse <= pulseNext;
        end
    end

    // DONE is only reachable in one-shot mode, so it doubles as the enable level.
    assign enable  = (state == DONE);
    assign running = (state == RUN);

endmodule

// File: tb/tb_interval_timer.sv
// Randomised and directed bench for interval_timer against an elapsed-cycle
// reference model, plus literal latency checks.
module tb_interval_timer;

    localparam int P  = 4;
    localparam int CW = 6;

    logic          clock = 1'b0;
    logic          reset, start, pause, autoReload;
    logic [CW-1:0] target, count;
    logic          enable, donePulse, running;

    logic          dStart;
    logic [5:0]    dCount;
    logic          dEnable, dPulse, dRunning;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int startCyc   = 0;
    bit checkOn    = 0;

    int mState = 0, mCount = 0, mTarget = 0, mElapsed = 0;
    bit mMode = 0, mPulse = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    interval_timer #(.PRESCALE(P), .PRE_W(8), .COUNT_W(CW)) dut (
        .clock(clock), .reset(reset), .start(start), .pause(pause),
        .auto_reload(autoReload), .target(target), .count(count),
        .enable(enable), .done_pulse(donePulse), .running(running)
    );

    interval_timer dutDefault (
        .clock(clock), .reset(reset), .start(dStart), .pause(1'b0),
        .auto_reload(1'b0), .target(6'd50), .count(dCount),
        .enable(dEnable), .done_pulse(dPulse), .running(dRunning)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0d, want %0d", name, $time, actual, expected);
        end
    endtask

    // Reference: track unpaused cycles elapsed since start; count and pulses follow by division.
    always @(posedge clock) begin : model
        int st, cnt, tgt, el;
        bit md, pl;
        st = mState; cnt = mCount; tgt = mTarget; el = mElapsed; md = mMode; pl = 0;
        if (reset) begin
            st = 0; cnt = 0; tgt = 0; el = 0; md = 0;
        end else if (start) begin
            tgt = int'(target); md = autoReload; el = 0; cnt = 0;
            if (tgt == 0) begin
                pl = 1;
                st = md ? 1 : 2;
            end else begin
                st = 1;
            end
        end else if (st == 1 && !pause) begin
            el++;
            if (tgt == 0) begin
                if (el == P) begin
                    pl = 1; el = 0;
                end
            end else begin
                cnt = el / P;
                if (el == P * tgt) begin
                    pl = 1;
                    if (md) begin
                        cnt = 0; el = 0;
                    end else begin
                        cnt = tgt; st = 2;
                    end
                end
            end
        end
        mState <= st; mCount <= cnt; mTarget <= tgt; mElapsed <= el; mMode <= md; mPulse <= pl;
    end

    always @(posedge clock) begin
        #1;
        if (checkOn) begin
            checkOutput("count", int'(count), mCount);
            checkOutput("done_pulse", int'(donePulse), int'(mPulse));
            checkOutput("enable", int'(enable), int'(mState == 2));
            checkOutput("running", int'(running), int'(mState == 1));
        end
    end

    task automatic applyStimulus(input logic s, input logic r, input logic p, input logic a, input int t);
        start = s; reset = r; pause = p; autoReload = a; target = CW'(t);
    endtask

    task automatic startTimer(input int t, input logic a);
        applyStimulus(1, 0, 0, a, t);
        @(posedge clock); #1;
        startCyc = cyc;
        start = 0;
    endtask

    task automatic waitEnable(input int limit, output int lat);
        lat = -1;
        for (int i = 0; i < limit; i++) begin
            @(posedge clock); #1;
            if (enable) begin
                lat = cyc - startCyc;
                break;
            end
        end
    endtask

    task automatic waitPulse(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(posedge clock); #1;
            if (donePulse) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic doReset();
        applyStimulus(0, 1, 0, 0, 0);
        @(posedge clock); #1;
        reset = 0;
    endtask

    initial begin
        int lat, prev, at;
        dStart = 0;
        applyStimulus(0, 1, 0, 0, 0);
        repeat (3) @(posedge clock);
        #1;
        reset = 0;
        checkOn = 1;
        checkOutput("reset_count", int'(count), 0);
        checkOutput("reset_running", int'(running), 0);

        // One-shot target 5
        @(posedge clock); #1;
        startTimer(5, 0);
        waitEnable(100, lat);
        checkOutput("oneshot_latency", lat, 20);
        checkOutput("oneshot_count", int'(count), 5);
        checkOutput("oneshot_pulse", int'(donePulse), 1);
        repeat (50) @(posedge clock);
        #1;
        checkOutput("oneshot_hold", int'(enable), 1);

        // Pause for 7 cycles mid-run
        startTimer(5, 0);
        repeat (5) @(posedge clock);
        #1; pause = 1;
        repeat (7) @(posedge clock);
        #1;
        checkOutput("pause_frozen", int'(count), 1);
        pause = 0;
        waitEnable(100, lat);
        checkOutput("pause_latency", lat, 27);

        // Restart with a new target partway through
        startTimer(5, 0);
        repeat (9) @(posedge clock);
        #1;
        startTimer(2, 0);
        checkOutput("restart_count", int'(count), 0);
        waitEnable(100, lat);
        checkOutput("restart_latency", lat, 8);

        // Auto-reload target 3: period of 12 cycles
        startTimer(3, 1);
        waitPulse(100, prev);
        checkOutput("reload_first", prev - startCyc, 12);
        for (int k = 0; k < 3; k++) begin
            waitPulse(100, at);
            checkOutput("reload_period", at - prev, 12);
            prev = at;
        end
        checkOutput("reload_enable", int'(enable), 0);
        doReset();

        // Target 0 one-shot, then reset in DONE
        startTimer(0, 0);
        checkOutput("zero_enable", int'(enable), 1);
        checkOutput("zero_pulse", int'(donePulse), 1);
        @(posedge clock); #1;
        checkOutput("zero_pulse_end", int'(donePulse), 0);
        doReset();
        checkOutput("zero_reset_enable", int'(enable), 0);

        // Reset beats start
        applyStimulus(1, 1, 0, 0, 5);
        @(posedge clock); #1;
        checkOutput("rst_start_running", int'(running), 0);
        checkOutput("rst_start_count", int'(count), 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Randomised phase
        for (int i = 0; i < 1500; i++) begin
            @(posedge clock); #1;
            applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 149) == 0),
                          ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 6)));
        end
        @(posedge clock); #1;
        applyStimulus(0, 0, 0, 0, 0);

        // Default parameters: target 50 takes 195*50 cycles
        dStart = 1;
        @(posedge clock); #1;
        dStart = 0;
        startCyc = cyc;
        lat = -1;
        for (int i = 0; i < 10000; i++) begin
            @(posedge clock); #1;
            if (dEnable) begin
                lat = cyc - startCyc;
                break;
            end
        end
        checkOutput("default_latency", lat, 9750);
        checkOutput("default_count", int'(dCount), 50);
        checkOutput("default_pulse", int'(dPulse), 1);
        checkOutput("default_running", int'(dRunning), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
